call_scheduler: RTL and testbench

Upstream request stage for the elevator car controller. It synchronises and debounces the three cabin buttons, holds one pending-request bit per floor (shown on `led1..3`), and picks the next target floor with a direction-keeping (SCAN) policy. It feeds `goal_floor`/`goal_valid` to the movement stage and consumes that stage's `floor`, `moving` and `door` status to retire served requests.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/button_debounce.sv | 43 ++++
 rtl/call_scheduler.sv | 168 ++++++++++++++++
 tb/tb_call_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants for the elevator controller: floor codes, the
// scheduler direction encoding and the floor-code width.
package elevator_pkg;

    localparam int FLOOR_W = 2;

    localparam logic [FLOOR_W-1:0] LABEL_F1 = 2'b00;
    localparam logic [FLOOR_W-1:0] LABEL_F2 = 2'b01;
    localparam logic [FLOOR_W-1:0] LABEL_F3 = 2'b10;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_HOLD = 2'b11
    } dir_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronises one raw cabin button, filters bounce with a stability
// counter and emits a one-cycle pulse on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic press
);

    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

    logic       sync1;
    logic       sync2;
    logic       stable;
    logic [7:0] cnt;

    // Two-flop synchroniser, stability counter and registered press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= 8'd0;
            press  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= 8'd0;
            end else if (cnt == LIMIT) begin
                stable <= sync2;
                cnt    <= 8'd0;
                press  <= sync2;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// Request stage of the elevator: debounced buttons set pending floor
// requests, served floors retire them, and a SCAN policy picks the goal.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 4,
    parameter logic [FLOOR_W-1:0] labelF1         = LABEL_F1,
    parameter logic [FLOOR_W-1:0] labelF2         = LABEL_F2,
    parameter logic [FLOOR_W-1:0] labelF3         = LABEL_F3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               button1,
    input  logic               button2,
    input  logic               button3,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               moving,
    input  logic               door,
    input  logic               sos_mode,
    input  logic               weight_limit_exceeded,
    output logic               led1,
    output logic               led2,
    output logic               led3,
    output logic [FLOOR_W-1:0] goal_floor,
    output logic               goal_valid,
    output logic [1:0]         direction
);

    logic [2:0]         press;
    logic [2:0]         pending_q, pending_d;
    logic [2:0]         serve;
    dir_t               dir_q, dir_d;
    logic [FLOOR_W-1:0] goal_d;
    logic               have_q, have_d;
    logic               valid_d;
    logic               pos_ok;
    logic [1:0]         pos;
    logic               above_vld, below_vld;
    logic [1:0]         above_idx, below_idx;

    function automatic logic [FLOOR_W-1:0] label_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return labelF1;
            2'd1:    return labelF2;
            default: return labelF3;
        endcase
    endfunction

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
        .clk(clk), .reset_n(reset_n), .button(button1), .press(press[0]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn2 (
        .clk(clk), .reset_n(reset_n), .button(button2), .press(press[1]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn3 (
        .clk(clk), .reset_n(reset_n), .button(button3), .press(press[2]));

    // Map the floor code onto a bottom-up position; unknown codes disable serve and goal update.
    always_comb begin
        pos_ok = 1'b1;
        pos    = 2'd0;
        if (floor == labelF1)      pos = 2'd0;
        else if (floor == labelF2) pos = 2'd1;
        else if (floor == labelF3) pos = 2'd2;
        else                       pos_ok = 1'b0;
    end

    assign serve = (pos_ok && door && !moving) ? (3'b001 << pos) : 3'b000;

    // Nearest pending floor strictly above and strictly below the car.
    always_comb begin
        above_vld = 1'b0;
        above_idx = 2'd0;
        below_vld = 1'b0;
        below_idx = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (pending_q[i] && i > int'(pos)) begin
                above_vld = 1'b1;
                above_idx = 2'(i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (pending_q[i] && i < int'(pos)) begin
                below_vld = 1'b1;
                below_idx = 2'(i);
            end
        end
    end

    // Next pending set, SCAN state and goal; sos overrides everything, serve beats a same-cycle press.
    always_comb begin
        pending_d = pending_q & ~serve;
        if (dir_q != DIR_HOLD) pending_d = pending_d | (press & ~serve);
        if (sos_mode) pending_d = 3'b000;

        dir_d  = dir_q;
        goal_d = goal_floor;
        have_d = have_q;

        if (sos_mode) begin
            dir_d  = DIR_HOLD;
            have_d = 1'b0;
        end else if (dir_q == DIR_HOLD) begin
            dir_d  = DIR_IDLE;
            have_d = 1'b0;
        end else if (!moving && pos_ok) begin
            have_d = 1'b1;
            if (pending_q[pos]) begin
                goal_d = label_of(pos);
            end else if (!above_vld && !below_vld) begin
                have_d = 1'b0;
                dir_d  = DIR_IDLE;
            end else begin
                case (dir_q)
                    DIR_UP: begin
                        if (above_vld) begin
                            goal_d = label_of(above_idx);
                        end else begin
                            goal_d = label_of(below_idx);
                            dir_d  = DIR_DOWN;
                        end
                    end
                    DIR_DOWN: begin
                        if (below_vld) begin
                            goal_d = label_of(below_idx);
                        end else begin
                            goal_d = label_of(above_idx);
                            dir_d  = DIR_UP;
                        end
                    end
                    default: begin
                        // Ties (only possible from the middle floor) go down.
                        if (below_vld && (!above_vld || (pos - below_idx) <= (above_idx - pos))) begin
                            goal_d = label_of(below_idx);
                            dir_d  = DIR_DOWN;
                        end else begin
                            goal_d = label_of(above_idx);
                            dir_d  = DIR_UP;
                        end
                    end
                endcase
            end
        end

        valid_d = have_d & ~weight_limit_exceeded;
    end

    // State register for pending requests, SCAN direction and goal outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 3'b000;
            dir_q      <= DIR_IDLE;
            goal_floor <= labelF1;
            have_q     <= 1'b0;
            goal_valid <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            dir_q      <= dir_d;
            goal_floor <= goal_d;
            have_q     <= have_d;
            goal_valid <= valid_d;
        end
    end

    assign led1      = pending_q[0];
    assign led2      = pending_q[1];
    assign led3      = pending_q[2];
    assign direction = dir_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler: directed sequences, a vector
// table and randomized traffic against a floor-level reference model.
module tb_call_scheduler;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       button1, button2, button3;
    logic [1:0] floor;
    logic       moving, door, sos_mode, weight_limit_exceeded;
    logic       led1, led2, led3;
    logic [1:0] goal_floor;
    logic       goal_valid;
    logic [1:0] direction;

    int total = 0;
    int bad   = 0;
    int ecount = 0;
    bit model_on = 1'b0;

    // reference model state: floors 1..3, dir 0=idle 1=up 2=down 3=hold
    bit m_pend [1:3];
    int m_dir, m_goal;
    bit m_have, m_gv;
    int pedge [3];

    always #5 clk = ~clk;

    call_scheduler #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .button1(button1), .button2(button2), .button3(button3),
        .floor(floor), .moving(moving), .door(door), .sos_mode(sos_mode),
        .weight_limit_exceeded(weight_limit_exceeded),
        .led1(led1), .led2(led2), .led3(led3),
        .goal_floor(goal_floor), .goal_valid(goal_valid), .direction(direction)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] leds, input logic [1:0] goal,
                             input logic gv, input logic [1:0] dir);
        chk({name, "_leds"}, 8'({led1, led2, led3}), 8'(leds));
        chk({name, "_goal"}, 8'(goal_floor), 8'(goal));
        chk({name, "_gv"},   8'(goal_valid), 8'(gv));
        chk({name, "_dir"},  8'(direction),  8'(dir));
    endtask

    task automatic choose(input int p);
        int best;
        bit any;
        best = 0;
        any = m_pend[1] | m_pend[2] | m_pend[3];
        if (m_pend[p]) begin
            m_goal = p;
            m_have = 1'b1;
        end else if (!any) begin
            m_have = 1'b0;
            m_dir  = 0;
        end else begin
            m_have = 1'b1;
            if (m_dir == 1 || m_dir == 2) begin
                for (int d = 1; d <= 2; d++) begin
                    int k;
                    k = (m_dir == 1) ? p + d : p - d;
                    if (best == 0 && k >= 1 && k <= 3 && m_pend[k]) best = k;
                end
                if (best == 0) begin
                    for (int d = 1; d <= 2; d++) begin
                        int k;
                        k = (m_dir == 1) ? p - d : p + d;
                        if (best == 0 && k >= 1 && k <= 3 && m_pend[k]) best = k;
                    end
                    m_dir = (m_dir == 1) ? 2 : 1;
                end
            end else begin
                for (int d = 1; d <= 2; d++) begin
                    if (best == 0 && p - d >= 1 && m_pend[p - d]) best = p - d;
                    else if (best == 0 && p + d <= 3 && m_pend[p + d]) best = p + d;
                end
                m_dir = (best > p) ? 1 : 2;
            end
            m_goal = best;
        end
    endtask

    task automatic model_edge(input int e);
        bit pok;
        int p;
        bit np [1:3];
        pok = (floor != 2'b11);
        p = int'(floor) + 1;
        for (int k = 1; k <= 3; k++) begin
            bit sv, pr;
            pr = (pedge[k-1] == e);
            sv = pok && (p == k) && door && !moving;
            np[k] = !sos_mode && ((m_pend[k] && !sv) || (pr && !sv && m_dir != 3));
        end
        if (sos_mode) begin
            m_dir = 3;
            m_have = 1'b0;
        end else if (m_dir == 3) begin
            m_dir = 0;
            m_have = 1'b0;
        end else if (!moving && pok) begin
            choose(p);
        end
        m_gv = m_have && !weight_limit_exceeded;
        for (int k = 1; k <= 3; k++) m_pend[k] = np[k];
    endtask

    task automatic step();
        @(posedge clk);
        if (model_on) model_edge(ecount);
        ecount++;
        #1;
    endtask

    task automatic clear_inputs();
        {button1, button2, button3} = 3'b000;
        floor = 2'b00;
        moving = 1'b0;
        door = 1'b0;
        sos_mode = 1'b0;
        weight_limit_exceeded = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] btn;
        logic [1:0] flr;
        logic       mov, dr, sos, wt;
        int         cyc;
        logic [2:0] leds;
        logic [1:0] goal;
        logic       gv;
        logic [1:0] dir;
    } vec_t;

    vec_t tbl [18];
    bit   lvl [3];
    int   left [3];

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 3'b000, 2'b00, 1'b0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;

        // clean button3 press from floor F1: led after edge 7, goal one edge later
        button3 = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            if (e == 6) chk("h1_led3_e6", 8'(led3), 8'd0);
            if (e == 7) begin
                chk("h1_led3_e7", 8'(led3), 8'd1);
                chk("h1_gv_e7", 8'(goal_valid), 8'd0);
            end
            if (e == 8) check_all("h1_e8", 3'b001, 2'b10, 1'b1, 2'b01);
        end
        repeat (11) step();
        button3 = 1'b0;
        repeat (8) step();

        // short bounce on button2 never becomes a press
        button2 = 1'b1; step();
        button2 = 1'b0; step();
        button2 = 1'b1; step();
        button2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("bounce_led2", 8'(led2), 8'd0);
        end

        // asynchronous reset in the middle of travel
        moving = 1'b1;
        floor = 2'b01;
        repeat (3) step();
        check_all("pre_areset", 3'b001, 2'b10, 1'b1, 2'b01);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("areset", 3'b000, 2'b00, 1'b0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;

        // vector table: {b1,b2,b3}, floor, moving, door, sos, weight, cycles -> {l1,l2,l3}, goal, gv, dir
        tbl[0]  = '{3'b000, 2'd1, 0, 0, 0, 0, 2,  3'b000, 2'd0, 0, 2'd0};
        tbl[1]  = '{3'b101, 2'd1, 0, 0, 0, 0, 10, 3'b101, 2'd0, 1, 2'd2};
        tbl[2]  = '{3'b000, 2'd1, 0, 0, 0, 0, 10, 3'b101, 2'd0, 1, 2'd2};
        tbl[3]  = '{3'b000, 2'd1, 1, 0, 0, 0, 3,  3'b101, 2'd0, 1, 2'd2};
        tbl[4]  = '{3'b000, 2'd0, 0, 1, 0, 0, 2,  3'b001, 2'd2, 1, 2'd1};
        tbl[5]  = '{3'b000, 2'd0, 1, 0, 0, 0, 2,  3'b001, 2'd2, 1, 2'd1};
        tbl[6]  = '{3'b100, 2'd1, 1, 0, 0, 0, 10, 3'b101, 2'd2, 1, 2'd1};
        tbl[7]  = '{3'b000, 2'd1, 0, 0, 0, 0, 10, 3'b101, 2'd2, 1, 2'd1};
        tbl[8]  = '{3'b000, 2'd2, 0, 1, 0, 0, 2,  3'b100, 2'd0, 1, 2'd2};
        tbl[9]  = '{3'b010, 2'd2, 0, 0, 0, 1, 10, 3'b110, 2'd1, 0, 2'd2};
        tbl[10] = '{3'b000, 2'd2, 0, 0, 0, 0, 1,  3'b110, 2'd1, 1, 2'd2};
        tbl[11] = '{3'b000, 2'd2, 0, 0, 1, 0, 1,  3'b000, 2'd1, 0, 2'd3};
        tbl[12] = '{3'b001, 2'd2, 0, 0, 1, 0, 10, 3'b000, 2'd1, 0, 2'd3};
        tbl[13] = '{3'b000, 2'd2, 0, 0, 1, 0, 8,  3'b000, 2'd1, 0, 2'd3};
        tbl[14] = '{3'b000, 2'd2, 0, 0, 0, 0, 1,  3'b000, 2'd1, 0, 2'd0};
        tbl[15] = '{3'b100, 2'd3, 0, 0, 0, 0, 10, 3'b100, 2'd1, 0, 2'd0};
        tbl[16] = '{3'b000, 2'd0, 0, 1, 0, 0, 1,  3'b000, 2'd0, 1, 2'd0};
        tbl[17] = '{3'b000, 2'd0, 0, 1, 0, 0, 1,  3'b000, 2'd0, 0, 2'd0};
        for (int r = 0; r < 18; r++) begin
            {button1, button2, button3} = tbl[r].btn;
            floor = tbl[r].flr;
            moving = tbl[r].mov;
            door = tbl[r].dr;
            sos_mode = tbl[r].sos;
            weight_limit_exceeded = tbl[r].wt;
            repeat (tbl[r].cyc) step();
            check_all($sformatf("row%0d", r), tbl[r].leds, tbl[r].goal, tbl[r].gv, tbl[r].dir);
        end

        // randomized traffic against the reference model
        do_reset();
        for (int k = 1; k <= 3; k++) m_pend[k] = 1'b0;
        m_dir = 0;
        m_goal = 1;
        m_have = 1'b0;
        m_gv = 1'b0;
        for (int b = 0; b < 3; b++) begin
            pedge[b] = -1;
            lvl[b] = 1'b0;
            left[b] = int'($urandom_range(1, 15));
        end
        ecount = 0;
        model_on = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                left[b]--;
                if (left[b] == 0) begin
                    lvl[b] = !lvl[b];
                    left[b] = int'($urandom_range(8, 15));
                    if (lvl[b]) pedge[b] = ecount + D + 3;
                end
            end
            {button1, button2, button3} = {lvl[0], lvl[1], lvl[2]};
            floor = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            moving = ($urandom_range(0, 2) == 0);
            door = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) sos_mode = !sos_mode;
            if ($urandom_range(0, 24) == 0) weight_limit_exceeded = !weight_limit_exceeded;
            step();
            check_all("rnd", {m_pend[1], m_pend[2], m_pend[3]}, 2'(m_goal - 1), m_gv, 2'(m_dir));
        end
        model_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
